// File: rtl/back_propagation.sv
// Back-propagation training stage for the 2-2-1 XOR network (8.8 signed fixed point).
// Captures one forward-pass snapshot, computes deltas and gradients, then applies a saturating SGD step.
module back_propagation #(
    parameter int LR_SHIFT  = 4,
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fp_valid,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] target,
    input  logic signed [15:0] h1,
    input  logic signed [15:0] h2,
    input  logic signed [15:0] y,
    input  logic signed [15:0] w11_in,
    input  logic signed [15:0] w12_in,
    input  logic signed [15:0] w21_in,
    input  logic signed [15:0] w22_in,
    input  logic signed [15:0] w31_in,
    input  logic signed [15:0] w32_in,
    input  logic signed [15:0] b1_in,
    input  logic signed [15:0] b2_in,
    input  logic signed [15:0] b3_in,
    output logic signed [15:0] w11_new,
    output logic signed [15:0] w12_new,
    output logic signed [15:0] w21_new,
    output logic signed [15:0] w22_new,
    output logic signed [15:0] w31_new,
    output logic signed [15:0] w32_new,
    output logic signed [15:0] b1_new,
    output logic signed [15:0] b2_new,
    output logic signed [15:0] b3_new,
    output logic               bp_busy,
    output logic               bp_valid,
    output logic        [15:0] update_count
);

    typedef enum logic [2:0] {IDLE, OUT_DELTA, HID_DELTA, GRAD, UPDATE, DONE} state_t;

    // Parameter slot order: w11, w12, w21, w22, w31, w32, b1, b2, b3
    localparam int NP = 9;

    state_t             state, next_state;
    logic               fp_valid_d;
    logic               start;
    logic signed [15:0] x1_r, x2_r, tgt_r, h1_r, h2_r, y_r;
    logic signed [15:0] p_r   [NP];
    logic signed [15:0] p_new [NP];
    logic signed [31:0] g     [NP];
    logic signed [15:0] d1, d2, d3;
    logic signed [31:0] prod_d1, prod_d2;

    assign start = fp_valid & ~fp_valid_d;

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'sh7FFF;
        else if (v < -34'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = OUT_DELTA;
            OUT_DELTA: next_state = HID_DELTA;
            HID_DELTA: next_state = GRAD;
            GRAD:      next_state = UPDATE;
            UPDATE:    next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        bp_busy = (state != IDLE);
    end

    // Hidden deltas back-propagate through the captured (pre-update) output weights
    always_comb begin
        prod_d1 = 32'(p_r[4]) * 32'(d3);
        prod_d2 = 32'(p_r[5]) * 32'(d3);
    end

    // NOTE: every register, datapath included, is async-reset so an aborted update leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp_valid_d   <= 1'b0;
            bp_valid     <= 1'b0;
            update_count <= '0;
            {x1_r, x2_r, tgt_r, h1_r, h2_r, y_r} <= '0;
            {d1, d2, d3} <= '0;
            for (int i = 0; i < NP; i++) begin
                p_r[i]   <= '0;
                p_new[i] <= '0;
                g[i]     <= '0;
            end
        end else begin
            fp_valid_d <= fp_valid;
            case (state)
                IDLE: if (start) begin
                    x1_r   <= x1;
                    x2_r   <= x2;
                    tgt_r  <= target;
                    h1_r   <= h1;
                    h2_r   <= h2;
                    y_r    <= y;
                    p_r[0] <= w11_in;
                    p_r[1] <= w12_in;
                    p_r[2] <= w21_in;
                    p_r[3] <= w22_in;
                    p_r[4] <= w31_in;
                    p_r[5] <= w32_in;
                    p_r[6] <= b1_in;
                    p_r[7] <= b2_in;
                    p_r[8] <= b3_in;
                end
                OUT_DELTA: d3 <= y_r - tgt_r;
                HID_DELTA: begin
                    d1 <= (h1_r != '0) ? 16'(prod_d1 >>> FRAC_BITS) : '0;
                    d2 <= (h2_r != '0) ? 16'(prod_d2 >>> FRAC_BITS) : '0;
                end
                GRAD: begin
                    g[0] <= (32'(d1) * 32'(x1_r)) >>> FRAC_BITS;
                    g[1] <= (32'(d1) * 32'(x2_r)) >>> FRAC_BITS;
                    g[2] <= (32'(d2) * 32'(x1_r)) >>> FRAC_BITS;
                    g[3] <= (32'(d2) * 32'(x2_r)) >>> FRAC_BITS;
                    g[4] <= (32'(d3) * 32'(h1_r)) >>> FRAC_BITS;
                    g[5] <= (32'(d3) * 32'(h2_r)) >>> FRAC_BITS;
                    g[6] <= 32'(d1);
                    g[7] <= 32'(d2);
                    g[8] <= 32'(d3);
                end
                UPDATE: begin
                    for (int i = 0; i < NP; i++)
                        p_new[i] <= sat16(34'(p_r[i]) - 34'(g[i] >>> LR_SHIFT));
                end
                default: ;
            endcase
            bp_valid <= (state == DONE);
            if (state == DONE) update_count <= update_count + 16'd1;
        end
    end

    assign w11_new = p_new[0];
    assign w12_new = p_new[1];
    assign w21_new = p_new[2];
    assign w22_new = p_new[3];
    assign w31_new = p_new[4];
    assign w32_new = p_new[5];
    assign b1_new  = p_new[6];
    assign b2_new  = p_new[7];
    assign b3_new  = p_new[8];

endmodule

// File: tb/tb_back_propagation.sv
// Self-checking bench for back_propagation: directed scenarios plus random snapshots
// compared against an integer-arithmetic model of the training step.
module tb_back_propagation;

    localparam int LR_SHIFT  = 4;
    localparam int FRAC_BITS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fp_valid = 1'b0;
    logic [15:0] s_x1, s_x2, s_tgt, s_h1, s_h2, s_y;
    logic [15:0] s_p [9];
    logic [15:0] w11_new, w12_new, w21_new, w22_new, w31_new, w32_new;
    logic [15:0] b1_new, b2_new, b3_new;
    logic        bp_busy, bp_valid;
    logic [15:0] update_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] exp_count = '0;
    string       pname [9] = '{"w11", "w12", "w21", "w22", "w31", "w32", "b1", "b2", "b3"};

    always #5 clk = ~clk;

    back_propagation #(.LR_SHIFT(LR_SHIFT), .FRAC_BITS(FRAC_BITS)) dut (
        .clk(clk), .rst(rst), .fp_valid(fp_valid),
        .x1(s_x1), .x2(s_x2), .target(s_tgt), .h1(s_h1), .h2(s_h2), .y(s_y),
        .w11_in(s_p[0]), .w12_in(s_p[1]), .w21_in(s_p[2]), .w22_in(s_p[3]),
        .w31_in(s_p[4]), .w32_in(s_p[5]),
        .b1_in(s_p[6]), .b2_in(s_p[7]), .b3_in(s_p[8]),
        .w11_new(w11_new), .w12_new(w12_new), .w21_new(w21_new), .w22_new(w22_new),
        .w31_new(w31_new), .w32_new(w32_new),
        .b1_new(b1_new), .b2_new(b2_new), .b3_new(b3_new),
        .bp_busy(bp_busy), .bp_valid(bp_valid), .update_count(update_count)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] e [9]);
        logic [15:0] o [9];
        o = '{w11_new, w12_new, w21_new, w22_new, w31_new, w32_new, b1_new, b2_new, b3_new};
        for (int i = 0; i < 9; i++) check({tag, "_", pname[i]}, o[i], e[i]);
    endtask

    // Reference model: plain integer arithmetic with floor division
    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint wrap16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return sx(t);
    endfunction

    function automatic logic [15:0] clamp16(input longint v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic void model(output logic [15:0] e [9]);
        longint fs, ls, d1, d2, d3;
        longint g [9];
        fs = longint'(1) << FRAC_BITS;
        ls = longint'(1) << LR_SHIFT;
        d3 = wrap16(sx(s_y) - sx(s_tgt));
        d1 = (s_h1 != 16'h0) ? wrap16(floor_div(sx(s_p[4]) * d3, fs)) : 0;
        d2 = (s_h2 != 16'h0) ? wrap16(floor_div(sx(s_p[5]) * d3, fs)) : 0;
        g[0] = floor_div(d1 * sx(s_x1), fs);
        g[1] = floor_div(d1 * sx(s_x2), fs);
        g[2] = floor_div(d2 * sx(s_x1), fs);
        g[3] = floor_div(d2 * sx(s_x2), fs);
        g[4] = floor_div(d3 * sx(s_h1), fs);
        g[5] = floor_div(d3 * sx(s_h2), fs);
        g[6] = d1;
        g[7] = d2;
        g[8] = d3;
        for (int i = 0; i < 9; i++) e[i] = clamp16(sx(s_p[i]) - floor_div(g[i], ls));
    endfunction

    task automatic set_base();
        s_x1 = 16'h0100; s_x2 = 16'h0000; s_h1 = 16'h0100; s_h2 = 16'h0000;
        s_y  = 16'h00C0; s_tgt = 16'h0100;
        s_p  = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0100,
                 16'h0000, 16'h0000, 16'h0000};
    endtask

    task automatic rand_stim();
        s_x1  = 16'($urandom);
        s_x2  = 16'($urandom);
        s_tgt = ($urandom_range(0, 1) != 0) ? 16'h0100 : 16'h0000;
        s_h1  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 32767));
        s_h2  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 32767));
        s_y   = 16'($urandom_range(0, 256));
        for (int i = 0; i < 9; i++) s_p[i] = 16'($urandom);
    endtask

    // Called at a negedge where the start is pending; changes inputs mid-flight to prove capture
    task automatic finish_update(input string tag, input logic [15:0] e [9]);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy"}, 16'(bp_busy), 16'd1);
                rand_stim();
            end
        end while (!bp_valid && cyc < 20);
        check({tag, "_latency"}, 16'(cyc), 16'd6);
        exp_count = exp_count + 16'd1;
        check_outputs(tag, e);
        check({tag, "_count"}, update_count, exp_count);
        fp_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 16'(bp_valid), 16'd0);
        check({tag, "_idle"}, 16'(bp_busy), 16'd0);
    endtask

    task automatic run_update(input string tag, input logic [15:0] e [9]);
        @(negedge clk);
        fp_valid = 1'b1;
        finish_update(tag, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e [9];
        logic [15:0] zero [9];
        int          pulses;

        zero = '{default: 16'h0};
        set_base();
        repeat (2) @(negedge clk);
        check_outputs("reset", zero);
        check("reset_busy", 16'(bp_busy), 16'd0);
        check("reset_valid", 16'(bp_valid), 16'd0);
        check("reset_count", update_count, 16'd0);
        rst = 1'b0;

        set_base();
        e = '{16'h0102, 16'h0000, 16'h0000, 16'h0000, 16'h0084, 16'h0100, 16'h0002, 16'h0000, 16'h0004};
        run_update("basic", e);

        set_base();
        s_h1 = 16'h0000;
        e = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0100, 16'h0000, 16'h0000, 16'h0004};
        run_update("relu", e);

        set_base();
        s_p[4] = 16'h7FFE; s_h1 = 16'h7F00; s_y = 16'h0000; s_tgt = 16'h0100;
        e = '{16'h0900, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0100, 16'h0800, 16'h0000, 16'h0010};
        run_update("sat_pos", e);

        set_base();
        s_p[4] = 16'h8001; s_h1 = 16'h7F00; s_y = 16'h0100; s_tgt = 16'h0000;
        e = '{16'h0900, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0100, 16'h0800, 16'h0000, 16'hFFF0};
        run_update("sat_neg", e);

        for (int n = 0; n < 12; n++) begin
            rand_stim();
            model(e);
            run_update($sformatf("rand%0d", n), e);
        end

        // Level held high: exactly one update
        set_base();
        model(e);
        @(negedge clk);
        fp_valid = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bp_valid) pulses++;
        end
        check("hold_pulses", 16'(pulses), 16'd1);
        exp_count = exp_count + 16'd1;
        check_outputs("hold", e);
        check("hold_count", update_count, exp_count);

        // Second rising edge while busy is dropped
        @(negedge clk) fp_valid = 1'b0;
        rand_stim();
        model(e);
        @(negedge clk) fp_valid = 1'b1;
        @(negedge clk) fp_valid = 1'b0;
        @(negedge clk) fp_valid = 1'b1;
        check("busy_restart", 16'(bp_busy), 16'd1);
        pulses = 0;
        @(negedge clk) fp_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bp_valid) pulses++;
        end
        check("ignored_pulses", 16'(pulses), 16'd1);
        exp_count = exp_count + 16'd1;
        check_outputs("ignored", e);
        check("ignored_count", update_count, exp_count);

        // Reset in GRAD aborts; a level still high afterwards gives one update
        set_base();
        @(negedge clk) fp_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs("abort", zero);
        check("abort_busy", 16'(bp_busy), 16'd0);
        check("abort_count", update_count, 16'd0);
        exp_count = '0;
        repeat (3) begin
            @(negedge clk);
            check("abort_valid", 16'(bp_valid), 16'd0);
        end
        model(e);
        rst = 1'b0;
        finish_update("post_reset", e);

        // Counter wrap
        @(negedge clk) force dut.update_count = 16'hFFFF;
        @(negedge clk) release dut.update_count;
        @(negedge clk);
        check("preload_count", update_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        rand_stim();
        model(e);
        run_update("wrap", e);
        check("wrap_zero", update_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
